// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, variable-latency memory between the IF stage (read-only) and the
// MEM stage (read/write). MEM has priority, a streak limiter protects IF, a watchdog ends hangs.
module unified_mem_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned MAX_MEM_STREAK = 4,
    parameter int unsigned TIMEOUT_CYC    = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_ready_o,
    input  logic          mem_req_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    output logic [DW-1:0] mem_rdata_o,
    output logic          mem_ready_o,
    output logic          err_o,
    output logic          dm_req_o,
    output logic          dm_we_o,
    output logic [AW-1:0] dm_addr_o,
    output logic [DW-1:0] dm_wdata_o,
    input  logic [DW-1:0] dm_rdata_i,
    input  logic          dm_ack_i
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, DONE} state_t;

    localparam int unsigned SW = $clog2(MAX_MEM_STREAK + 1);
    localparam int unsigned WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);
    localparam logic [WW-1:0] WD_LAST    = WW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam bit            WD_EN      = (TIMEOUT_CYC != 0);

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q;
    logic [WW-1:0] wdog_q;
    logic          grant_if, grant_mem, finish, timed_out;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                // IF overrides MEM only once MEM has won MAX_MEM_STREAK times while IF waited.
                if (mem_req_i && !(if_req_i && streak_q == STREAK_MAX)) begin
                    grant_mem = 1'b1;
                    state_d   = BUSY_MEM;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                    state_d  = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (dm_ack_i) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else if (WD_EN && wdog_q == WD_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            streak_q    <= '0;
            wdog_q      <= '0;
            dm_req_o    <= 1'b0;
            dm_we_o     <= 1'b0;
            dm_addr_o   <= '0;
            dm_wdata_o  <= '0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            err_o       <= 1'b0;

            if (grant_mem || grant_if) begin
                dm_req_o   <= 1'b1;
                dm_we_o    <= grant_mem & mem_we_i;
                dm_addr_o  <= grant_mem ? mem_addr_i : if_addr_i;
                dm_wdata_o <= grant_mem ? mem_wdata_i : '0;
                wdog_q     <= '0;
                if (grant_if || !if_req_i)      streak_q <= '0;
                else if (streak_q != STREAK_MAX) streak_q <= streak_q + SW'(1);
            end

            if (WD_EN && (state_q == BUSY_IF || state_q == BUSY_MEM) && !finish)
                wdog_q <= wdog_q + WW'(1);

            if (finish) begin
                dm_req_o <= 1'b0;
                err_o    <= timed_out;
                if (state_q == BUSY_IF) begin
                    if_ready_o <= 1'b1;
                    if_rdata_o <= timed_out ? '0 : dm_rdata_i;
                end else begin
                    mem_ready_o <= 1'b1;
                    mem_rdata_o <= (timed_out || dm_we_o) ? '0 : dm_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized two-requester traffic,
// scored against a transaction-level model of grants, latency, streak limit and timeout.
module tb_unified_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    typedef enum {S_NONE, S_IF, S_MEM} side_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic [DW-1:0] if_rdata_o;
    logic          if_ready_o;
    logic          mem_req_i = 1'b0;
    logic          mem_we_i = 1'b0;
    logic [AW-1:0] mem_addr_i = '0;
    logic [DW-1:0] mem_wdata_i = '0;
    logic [DW-1:0] mem_rdata_o;
    logic          mem_ready_o;
    logic          err_o;
    logic          dm_req_o;
    logic          dm_we_o;
    logic [AW-1:0] dm_addr_o;
    logic [DW-1:0] dm_wdata_o;
    logic [DW-1:0] dm_rdata_i = '0;
    logic          dm_ack_i = 1'b0;

    always #5 clk_i = ~clk_i;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .MAX_MEM_STREAK(MAXS), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
        .err_o(err_o), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
        .dm_wdata_o(dm_wdata_o), .dm_rdata_i(dm_rdata_i), .dm_ack_i(dm_ack_i)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Downstream memory and responder controls
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    bit resp_en = 1'b1;
    bit rand_lat = 1'b0;
    int fixed_lat = 0;
    int cur_lat = 0;
    int lat_cnt = 0;

    // Transaction in flight, as predicted by the model
    side_t            g_side = S_NONE;
    logic [AW+DW:0]   g_fields = '0;
    bit               pend = 1'b0;
    bit               acked = 1'b0;
    logic [DW-1:0]    exp_rdata = '0;
    int               grant_cyc = 0;
    int               run = 0;
    side_t            grant_log[$];
    logic             obs_grant_we = 1'b0;
    int               n_if_rdy = 0;
    int               n_mem_rdy = 0;
    bit               saw_if = 1'b0;
    bit               saw_mem = 1'b0;
    logic             dm_req_prev = 1'b0;
    logic             if_ready_prev = 1'b0;
    logic             mem_ready_prev = 1'b0;

    // One clock: sample at the falling edge, score completions and grants, play the responder.
    task automatic cycle();
        side_t          s;
        side_t          exp_side;
        logic [AW+DW:0] obs_f;
        logic [AW+DW:0] exp_f;
        logic [DW-1:0]  rd;
        logic [DW-1:0]  want;
        int             gap;
        @(negedge clk_i);
        cyc++;
        saw_if  = if_ready_o;
        saw_mem = mem_ready_o;
        if (if_ready_o)  n_if_rdy++;
        if (mem_ready_o) n_mem_rdy++;

        if (if_ready_o || mem_ready_o || err_o) begin
            n_cmp++;
            if (!pend || (if_ready_o && mem_ready_o) || (if_ready_o && if_ready_prev) ||
                (mem_ready_o && mem_ready_prev) || !(if_ready_o || mem_ready_o)) begin
                n_bad++;
                $display("FAIL ready_pulse: if_ready=%0b mem_ready=%0b err=%0b, required single pulse for pending access (pending=%0b)",
                         if_ready_o, mem_ready_o, err_o, pend);
            end else begin
                s    = if_ready_o ? S_IF : S_MEM;
                rd   = if_ready_o ? if_rdata_o : mem_rdata_o;
                want = acked ? exp_rdata : '0;
                gap  = cyc - grant_cyc;
                n_cmp++;
                if (s !== g_side) begin
                    n_bad++;
                    $display("FAIL ready_side: got %s, required %s", s.name(), g_side.name());
                end
                n_cmp++;
                if (err_o !== !acked) begin
                    n_bad++;
                    $display("FAIL ready_err: err_o=%0b, required %0b", err_o, !acked);
                end
                n_cmp++;
                if (rd !== want) begin
                    n_bad++;
                    $display("FAIL ready_rdata: got %h, required %h", rd, want);
                end
                n_cmp++;
                if (gap != (acked ? cur_lat + 1 : TMO)) begin
                    n_bad++;
                    $display("FAIL ready_latency: dm_req-to-ready %0d cycles, required %0d",
                             gap, acked ? cur_lat + 1 : TMO);
                end
            end
            pend = 1'b0;
        end

        obs_f = {dm_we_o, dm_addr_o, dm_wdata_o};
        if (dm_req_o && !dm_req_prev) begin
            s = S_NONE;
            if (if_req_i && mem_req_i) begin
                exp_side = (run == MAXS) ? S_IF : S_MEM;
                s = (obs_f == {mem_we_i, mem_addr_i, mem_wdata_i}) ? S_MEM : S_IF;
                n_cmp++;
                if (s !== exp_side) begin
                    n_bad++;
                    $display("FAIL grant_priority: granted %s with streak %0d, required %s",
                             s.name(), run, exp_side.name());
                end
            end else if (if_req_i)  s = S_IF;
            else if (mem_req_i)     s = S_MEM;
            n_cmp++;
            if (s == S_NONE || pend) begin
                n_bad++;
                $display("FAIL grant_legal: dm_req rose with if_req=%0b mem_req=%0b pending=%0b, required a request and no access in flight",
                         if_req_i, mem_req_i, pend);
            end
            exp_f = (s == S_MEM) ? {mem_we_i, mem_addr_i, mem_wdata_i} : {1'b0, if_addr_i, {DW{1'b0}}};
            n_cmp++;
            if (obs_f !== exp_f) begin
                n_bad++;
                $display("FAIL grant_fields: we/addr/wdata %h, required %h", obs_f, exp_f);
            end
            obs_grant_we = dm_we_o;
            g_side   = s;
            g_fields = exp_f;
            pend     = 1'b1;
            acked    = 1'b0;
            grant_cyc = cyc;
            lat_cnt  = 0;
            cur_lat  = rand_lat ? int'($urandom_range(0, 5)) : fixed_lat;
            grant_log.push_back(s);
            if (s == S_IF || !if_req_i) run = 0;
            else if (run < MAXS)        run = run + 1;
        end else if (dm_req_o && pend) begin
            n_cmp++;
            if (obs_f !== g_fields) begin
                n_bad++;
                $display("FAIL busy_hold: we/addr/wdata %h, required %h", obs_f, g_fields);
            end
        end

        if (dm_ack_i) begin
            dm_ack_i = 1'b0;
        end else if (resp_en && dm_req_o && pend && !acked) begin
            if (lat_cnt == cur_lat) begin
                if (g_fields[AW+DW]) begin
                    rd = $urandom();
                    mem_model[g_fields[AW+DW-1:DW]] = g_fields[DW-1:0];
                end else if (mem_model.exists(g_fields[AW+DW-1:DW])) begin
                    rd = mem_model[g_fields[AW+DW-1:DW]];
                end else begin
                    rd = $urandom();
                end
                exp_rdata  = g_fields[AW+DW] ? '0 : rd;
                dm_rdata_i = rd;
                dm_ack_i   = 1'b1;
                acked      = 1'b1;
            end else begin
                lat_cnt++;
            end
        end

        dm_req_prev    = dm_req_o;
        if_ready_prev  = if_ready_o;
        mem_ready_prev = mem_ready_o;
    endtask

    task automatic await_ready(input side_t s, input int max, input string name, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!((s == S_IF) ? saw_if : saw_mem) && n < max);
        n_cmp++;
        if (!((s == S_IF) ? saw_if : saw_mem)) begin
            n_bad++;
            $display("FAIL %s_timeout: no ready within %0d cycles, required a ready pulse", name, n);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) cycle();
        n_cmp++;
        if ({if_ready_o, mem_ready_o, err_o, dm_req_o, dm_we_o, dm_addr_o, dm_wdata_o, if_rdata_o, mem_rdata_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: dm_req=%0b dm_addr=%h if_rdata=%h mem_rdata=%h, required all 0",
                     dm_req_o, dm_addr_o, if_rdata_o, mem_rdata_o);
        end
        rst_i = 1'b1;
        repeat (2) cycle();
        n_cmp++;
        if ({dm_req_o, if_ready_o, mem_ready_o, err_o} !== 4'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: dm_req=%0b readies=%0b%0b err=%0b, required 0",
                     dm_req_o, if_ready_o, mem_ready_o, err_o);
        end
    endtask

    task automatic test_if_read();
        int n;
        mem_model[32'h10] = 32'h0050_0093;
        resp_en = 1'b1; rand_lat = 1'b0; fixed_lat = 1;
        if_addr_i = 32'h10;
        if_req_i  = 1'b1;
        await_ready(S_IF, 20, "if_read", n);
        if_req_i = 1'b0;
        n_cmp++;
        if (n != 3) begin
            n_bad++;
            $display("FAIL if_read_latency: request-to-ready %0d cycles, required 3", n);
        end
        n_cmp++;
        if (if_rdata_o !== 32'h0050_0093) begin
            n_bad++;
            $display("FAIL if_read_data: got %h, required 00500093", if_rdata_o);
        end
        n_cmp++;
        if (obs_grant_we !== 1'b0) begin
            n_bad++;
            $display("FAIL if_read_we: dm_we_o=%0b, required 0", obs_grant_we);
        end
        cycle();
        n_cmp++;
        if (if_ready_o !== 1'b0 || if_rdata_o !== 32'h0050_0093) begin
            n_bad++;
            $display("FAIL if_read_pulse: if_ready=%0b if_rdata=%h, required 0 and held 00500093",
                     if_ready_o, if_rdata_o);
        end
    endtask

    task automatic test_mem_write_read();
        int n;
        int base;
        resp_en = 1'b1; rand_lat = 1'b1;
        base = n_mem_rdy;
        mem_we_i = 1'b1; mem_addr_i = 32'h20; mem_wdata_i = 32'hDEAD_BEEF;
        mem_req_i = 1'b1;
        await_ready(S_MEM, 20, "mem_write", n);
        mem_req_i = 1'b0;
        n_cmp++;
        if (mem_rdata_o !== '0) begin
            n_bad++;
            $display("FAIL mem_write_rdata: got %h, required 0", mem_rdata_o);
        end
        cycle();
        mem_we_i = 1'b0; mem_wdata_i = $urandom();
        mem_req_i = 1'b1;
        await_ready(S_MEM, 20, "mem_read", n);
        mem_req_i = 1'b0;
        n_cmp++;
        if (mem_rdata_o !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL mem_read_data: got %h, required deadbeef", mem_rdata_o);
        end
        repeat (3) cycle();
        n_cmp++;
        if (n_mem_rdy - base != 2) begin
            n_bad++;
            $display("FAIL mem_ready_count: %0d pulses, required 2", n_mem_rdy - base);
        end
    endtask

    task automatic test_streak();
        int k;
        side_t want;
        resp_en = 1'b1; rand_lat = 1'b0; fixed_lat = 0;
        if_addr_i = 32'h100; mem_addr_i = 32'h8000_0200; mem_we_i = 1'b0;
        grant_log.delete();
        if_req_i = 1'b1; mem_req_i = 1'b1;
        k = 0;
        while (grant_log.size() < 10 && k < 200) begin cycle(); k++; end
        while (pend && k < 200) begin cycle(); k++; end
        if_req_i = 1'b0; mem_req_i = 1'b0;
        n_cmp++;
        if (grant_log.size() < 10) begin
            n_bad++;
            $display("FAIL streak_grants: %0d grants seen, required 10", grant_log.size());
        end
        for (int i = 0; i < 10 && i < grant_log.size(); i++) begin
            want = (i % 5 == 4) ? S_IF : S_MEM;
            n_cmp++;
            if (grant_log[i] !== want) begin
                n_bad++;
                $display("FAIL streak_order[%0d]: got %s, required %s", i, grant_log[i].name(), want.name());
            end
        end
        repeat (2) cycle();
    endtask

    task automatic test_timeout();
        int n;
        resp_en = 1'b0;
        mem_we_i = 1'b0; mem_addr_i = 32'h20;
        mem_req_i = 1'b1;
        await_ready(S_MEM, 30, "timeout", n);
        mem_req_i = 1'b0;
        n_cmp++;
        if (n != TMO + 1 || err_o !== 1'b1 || mem_rdata_o !== '0) begin
            n_bad++;
            $display("FAIL timeout_done: after %0d cycles err=%0b rdata=%h, required %0d cycles err=1 rdata=0",
                     n, err_o, mem_rdata_o, TMO + 1);
        end
        cycle();
        n_cmp++;
        if (err_o !== 1'b0 || mem_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse: err=%0b mem_ready=%0b one cycle later, required 0", err_o, mem_ready_o);
        end
        resp_en = 1'b1;
    endtask

    task automatic test_reset_midflight();
        int n;
        resp_en = 1'b0;
        mem_we_i = 1'b0; mem_addr_i = 32'h40;
        mem_req_i = 1'b1;
        repeat (4) cycle();
        #2 rst_i = 1'b0;
        pend = 1'b0; run = 0; dm_ack_i = 1'b0;
        mem_req_i = 1'b0;
        #1;
        n_cmp++;
        if (dm_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_drop: dm_req_o=%0b right after reset, required 0", dm_req_o);
        end
        repeat (3) begin
            cycle();
            n_cmp++;
            if ({dm_req_o, mem_ready_o, if_ready_o, err_o, dm_addr_o} !== '0) begin
                n_bad++;
                $display("FAIL reset_hold: dm_req=%0b mem_ready=%0b dm_addr=%h, required 0",
                         dm_req_o, mem_ready_o, dm_addr_o);
            end
        end
        rst_i = 1'b1;
        resp_en = 1'b1; rand_lat = 1'b0; fixed_lat = 2;
        mem_model[32'h44] = 32'h1357_9BDF;
        if_addr_i = 32'h44;
        if_req_i  = 1'b1;
        await_ready(S_IF, 20, "post_reset_if", n);
        if_req_i = 1'b0;
        n_cmp++;
        if (n != 4 || if_rdata_o !== 32'h1357_9BDF) begin
            n_bad++;
            $display("FAIL post_reset_if: %0d cycles rdata=%h, required 4 cycles rdata 13579bdf", n, if_rdata_o);
        end
        cycle();
    endtask

    task automatic test_spurious_ack();
        int n;
        resp_en = 1'b1; rand_lat = 1'b0; fixed_lat = 1;
        mem_we_i = 1'b0; mem_addr_i = 32'h20;
        mem_req_i = 1'b1;
        await_ready(S_MEM, 20, "pre_spurious", n);
        mem_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dm_ack_i   = 1'b1;
            dm_rdata_i = 32'h0BAD_0000 + i;
            cycle();
            n_cmp++;
            if (mem_rdata_o !== 32'hDEAD_BEEF || {mem_ready_o, if_ready_o, err_o, dm_req_o} !== 4'b0) begin
                n_bad++;
                $display("FAIL spurious_ack[%0d]: mem_rdata=%h ready=%0b%0b dm_req=%0b, required deadbeef and no activity",
                         i, mem_rdata_o, mem_ready_o, if_ready_o, dm_req_o);
            end
        end
        mem_model[32'h48] = 32'h2468_ACE0;
        if_addr_i = 32'h48;
        if_req_i  = 1'b1;
        await_ready(S_IF, 20, "post_spurious_if", n);
        if_req_i = 1'b0;
        n_cmp++;
        if (if_rdata_o !== 32'h2468_ACE0) begin
            n_bad++;
            $display("FAIL post_spurious_if: rdata=%h, required 2468ace0", if_rdata_o);
        end
        cycle();
    endtask

    task automatic test_random_traffic();
        int if_left;
        int mem_left;
        int k;
        int if_base;
        int mem_base;
        resp_en = 1'b1; rand_lat = 1'b1;
        if_left = 40; mem_left = 40; k = 0;
        if_base = n_if_rdy; mem_base = n_mem_rdy;
        while ((if_left > 0 || mem_left > 0 || if_req_i || mem_req_i) && k < 4000) begin
            cycle();
            k++;
            if (if_req_i && saw_if) begin
                if_req_i = 1'b0;
                if_left--;
            end else if (!if_req_i && if_left > 0 && $urandom_range(0, 2) == 0) begin
                if_addr_i = $urandom() & 32'h7FFF_FFFC;
                if_req_i  = 1'b1;
            end
            if (mem_req_i && saw_mem) begin
                mem_req_i = 1'b0;
                mem_left--;
            end else if (!mem_req_i && mem_left > 0 && $urandom_range(0, 1) == 0) begin
                mem_addr_i  = 32'h8000_0000 | ($urandom() & 32'h0000_003C);
                mem_we_i    = 1'($urandom_range(0, 1));
                mem_wdata_i = $urandom();
                mem_req_i   = 1'b1;
            end
        end
        repeat (3) cycle();
        n_cmp++;
        if (k >= 4000 || n_if_rdy - if_base != 40 || n_mem_rdy - mem_base != 40) begin
            n_bad++;
            $display("FAIL traffic_complete: %0d IF and %0d MEM completions in %0d cycles, required 40 each",
                     n_if_rdy - if_base, n_mem_rdy - mem_base, k);
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_mem_write_read();
        test_streak();
        test_timeout();
        test_reset_midflight();
        test_spurious_ack();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule
